intc_prio_arb: RTL and testbench
================================

# intc_prio_arb

Priority resolution and CPU handshake stage of the interrupt controller. Sits directly downstream of the normal-interrupt capture stage. It takes the captured pending vector `in_intreq` plus per-source priority registers and finds the highest-priority unmasked source. It presents level and vector to the CPU and, on CPU acknowledge, returns a one-hot `cp_intack` pulse so the capture stage clears the accepted source.

## Interface
Parameters:
- `INT_DW`, 64: number of normal interrupt sources; multiple of 8, max 256.
- `VEC_BASE`, 8'd64: vector number of source 0; vector = `VEC_BASE` + index, modulo 256.

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_intreq_i`  in  INT_DW  pending requests from capture stage.
- `rg_ipr_i`  in  INT_DW×4  per-source priority; 0 disables the source.
- `rg_imask_i`  in  4  CPU mask level; a source competes only if its priority is greater than this value.
- `intc_req_o`  out  1  interrupt request to CPU.
- `intc_level_o`  out  4  priority of the presented source.
- `intc_vec_o`  out  8  vector of the presented source.
- `cpu_ack_i`  in  1  single-cycle acknowledge from CPU.
- `cp_intack_o`  out  INT_DW  one-hot acknowledge pulse to capture stage.

## Operation
- Eligible source: `in_intreq_i[i]`=1, `rg_ipr_i[i]`≠0 and `rg_ipr_i[i]` > `rg_imask_i`.
- Winner: the eligible source with the highest priority. On equal priority, the lowest index wins.
- Stage 1: eight-source groups each produce a registered local winner (valid, level, index).
- Stage 2: the group winners are reduced to a registered global winner (valid, level, index).
- FSM states:
  - IDLE: `intc_req_o`=0. Go to REQ when the global winner is valid.
  - REQ: `intc_req_o`=1. Level and vector track the global winner every cycle, so a higher-priority source preempts before ack.
    - Winner becomes invalid with no ack (source masked or withdrawn): go to IDLE.
    - `cpu_ack_i`=1: capture the index currently on the outputs, drive `cp_intack_o` one-hot for exactly 1 cycle, go to FLUSH.
  - FLUSH: `intc_req_o`=0. Hold for `FLUSH_CYC` cycles so the cleared source drains from the pipeline, then go to IDLE.
- `cpu_ack_i` outside REQ is ignored, and `cp_intack_o` stays 0.
- Ack and a winner change in the same cycle: the acked index is the one on the registered outputs in that cycle, not the new winner.
- A change to `rg_imask_i` takes effect through the pipeline; no special handling.

## Timing
- Reset values: `intc_req_o`=0, `intc_level_o`=0, `intc_vec_o`=0, `cp_intack_o`=0; FSM in IDLE; all pipeline valids 0.
- Latency from an `in_intreq_i` rise to `intc_req_o`=1: 3 cycles with the pipeline (2 stages + FSM), 2 cycles without.
- `cp_intack_o` asserts the cycle after `cpu_ack_i` is sampled.
- `FLUSH_CYC` = pipeline depth + 1: 3 with the pipeline, 2 without.
- Reset asserted mid-handshake clears everything asynchronously. No ack pulse is emitted, and the pending bits in the capture stage remain set.
- Back-to-back: the earliest next `intc_req_o` is `FLUSH_CYC`+1 cycles after ack.

## Configuration
- `INTC_PRIO_PIPE_EN` defined: two registered stages (group, then global); `FLUSH_CYC`=3.
- `INTC_PRIO_PIPE_EN` not defined: group and global reduction are one combinational cone into a single register; `FLUSH_CYC`=2.
- Winner selection and handshake behaviour are identical in both builds; only latencies shift.

## Structure
Shared package `intc_pkg` holds:
- `intc_prio_t` (logic [3:0]).
- The FSM enum `intc_arb_st_e` {IDLE, REQ, FLUSH}.
- The winner struct {valid, level, index}.
- `INTC_GRP_W`=8.

Sub-module `intc_prio_grp` is a combinational eight-input max-priority finder with lowest-index tie-break. It is instantiated INT_DW/8 times for the groups and once for the global reduction.

## Test plan
- Source 5 at priority 3, mask 0 -> `intc_req_o`=1 after 3 cycles, level=3, vec=69. Ack -> `cp_intack_o`=1<<5 for 1 cycle, then FLUSH, then IDLE.
- Sources 2 and 40 both at priority 7 -> vec=66 (lowest index). Source 40 raised to 9 while in REQ -> outputs switch to level 9, vec=104.
- Source 10 at priority 4 with mask 4 -> no request. Lower mask to 3 -> request appears, level 4.
- Ack in the same cycle that a higher-priority source arrives -> pulse on the previously presented index only. The new source is presented after FLUSH.
- Ack while IDLE -> `cp_intack_o` stays 0.
- `rst_n` low while in REQ -> all outputs 0 immediately. After release with request held -> re-request after 3 cycles.

Source files
------------

// File: rtl/intc_pkg.sv
// -----------------------------------------------------------------------------
// intc_pkg
//
// Shared types and constants for the interrupt controller priority arbiter.
//   INTC_GRP_W    : number of sources reduced by one group finder
//   INTC_IDX_W    : width of a source index (covers up to 256 sources)
//   intc_prio_t   : 4-bit priority / mask level
//   intc_arb_st_e : CPU handshake FSM states
//   intc_win_t    : winner record {valid, level, index}
// -----------------------------------------------------------------------------
package intc_pkg;

    localparam int unsigned INTC_GRP_W = 8;
    localparam int unsigned INTC_IDX_W = 8;

    typedef logic [3:0] intc_prio_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } intc_arb_st_e;

    typedef struct packed {
        logic                  valid;
        intc_prio_t            level;
        logic [INTC_IDX_W-1:0] index;
    } intc_win_t;

endpackage

// File: rtl/intc_prio_grp.sv
// -----------------------------------------------------------------------------
// intc_prio_grp
//
// Combinational max-priority finder over NumIn candidates. Among the valid
// candidates the highest level wins; equal levels resolve to the lowest index.
// Used for the eight-source groups and for the reduction of group winners.
//
// Ports:
//   valid_i : per-candidate valid
//   level_i : per-candidate level, candidate k at [k*4 +: 4]
//   valid_o : at least one candidate valid
//   level_o : level of the winner (0 when none valid)
//   index_o : local index of the winner (0 when none valid)
// -----------------------------------------------------------------------------
module intc_prio_grp
    import intc_pkg::*;
#(
    parameter int unsigned NumIn = INTC_GRP_W
) (
    input  logic [NumIn-1:0]      valid_i,
    input  logic [NumIn*4-1:0]    level_i,
    output logic                  valid_o,
    output intc_prio_t            level_o,
    output logic [INTC_IDX_W-1:0] index_o
);

    logic                  best_v;
    intc_prio_t            best_l;
    logic [INTC_IDX_W-1:0] best_i;

    // Ascending scan with a strict compare keeps the lowest index on ties.
    always_comb begin
        best_v = 1'b0;
        best_l = '0;
        best_i = '0;
        for (int unsigned i = 0; i < NumIn; i++) begin
            if (valid_i[i] && (!best_v || (level_i[i*4 +: 4] > best_l))) begin
                best_v = 1'b1;
                best_l = level_i[i*4 +: 4];
                best_i = INTC_IDX_W'(i);
            end
        end
    end

    assign valid_o = best_v;
    assign level_o = best_l;
    assign index_o = best_i;

endmodule

// File: rtl/intc_prio_arb.sv
// -----------------------------------------------------------------------------
// intc_prio_arb
//
// Priority resolution and CPU handshake stage of the interrupt controller.
// Finds the highest-priority unmasked pending source, presents its level and
// vector to the CPU, and on acknowledge returns a one-hot pulse to the capture
// stage so it can clear the accepted source.
//
// Build option (macro INTC_PRIO_PIPE_EN):
//   defined   : group winners and global winner each registered; the request
//               follows a pending rise by 3 cycles; flush lasts 3 cycles.
//   undefined : group and global reduction form one combinational cone into a
//               single register; request latency 2 cycles; flush lasts 2.
//
// Parameters:
//   INT_DW   : number of sources (multiple of 8, at most 256)
//   VEC_BASE : vector of source 0; vector = VEC_BASE + index (mod 256)
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_intreq_i  : pending requests from the capture stage
//   rg_ipr_i     : per-source priority, source k at [k*4 +: 4]; 0 disables
//   rg_imask_i   : CPU mask; a source competes only if its priority exceeds it
//   intc_req_o   : interrupt request to the CPU
//   intc_level_o : priority of the presented source
//   intc_vec_o   : vector of the presented source
//   cpu_ack_i    : single-cycle acknowledge from the CPU
//   cp_intack_o  : one-hot, one-cycle acknowledge to the capture stage
// -----------------------------------------------------------------------------
module intc_prio_arb
    import intc_pkg::*;
#(
    parameter int unsigned INT_DW   = 64,
    parameter logic [7:0]  VEC_BASE = 8'd64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INT_DW-1:0]   in_intreq_i,
    input  logic [INT_DW*4-1:0] rg_ipr_i,
    input  intc_prio_t          rg_imask_i,
    output logic                intc_req_o,
    output intc_prio_t          intc_level_o,
    output logic [7:0]          intc_vec_o,
    input  logic                cpu_ack_i,
    output logic [INT_DW-1:0]   cp_intack_o
);

    localparam int unsigned NumGrp = INT_DW / INTC_GRP_W;

    // Flush covers the pipeline depth plus the cycle the capture stage needs
    // to clear the acknowledged bit.
`ifdef INTC_PRIO_PIPE_EN
    localparam int unsigned FLUSH_CYC = 3;
`else
    localparam int unsigned FLUSH_CYC = 2;
`endif

    // -------------------------------------------------------------------------
    // Eligibility
    // -------------------------------------------------------------------------
    logic [INT_DW-1:0] elig;

    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < INT_DW; i++) begin
            elig[i] = in_intreq_i[i] && (rg_ipr_i[i*4 +: 4] != '0) &&
                      (rg_ipr_i[i*4 +: 4] > rg_imask_i);
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1: per-group winners
    // -------------------------------------------------------------------------
    intc_win_t [NumGrp-1:0] grp_win;

    for (genvar g = 0; g < NumGrp; g++) begin : g_grp
        logic                  grp_v;
        intc_prio_t            grp_l;
        logic [INTC_IDX_W-1:0] grp_i;

        intc_prio_grp #(
            .NumIn (INTC_GRP_W)
        ) u_grp (
            .valid_i (elig[g*INTC_GRP_W +: INTC_GRP_W]),
            .level_i (rg_ipr_i[g*INTC_GRP_W*4 +: INTC_GRP_W*4]),
            .valid_o (grp_v),
            .level_o (grp_l),
            .index_o (grp_i)
        );

        // Local index rebased to the global source number.
        assign grp_win[g].valid = grp_v;
        assign grp_win[g].level = grp_l;
        assign grp_win[g].index = grp_v ? (INTC_IDX_W'(g * INTC_GRP_W) + grp_i) : '0;
    end

    intc_win_t [NumGrp-1:0] grp_sel;

`ifdef INTC_PRIO_PIPE_EN
    intc_win_t [NumGrp-1:0] grp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_q <= '0;
        end else begin
            grp_q <= grp_win;
        end
    end

    assign grp_sel = grp_q;
`else
    assign grp_sel = grp_win;
`endif

    // -------------------------------------------------------------------------
    // Stage 2: global winner over the group winners
    // -------------------------------------------------------------------------
    logic [NumGrp-1:0]     glb_valid_in;
    logic [NumGrp*4-1:0]   glb_level_in;
    logic                  glb_v;
    intc_prio_t            glb_l;
    logic [INTC_IDX_W-1:0] glb_g;

    always_comb begin
        glb_valid_in = '0;
        glb_level_in = '0;
        for (int unsigned g = 0; g < NumGrp; g++) begin
            glb_valid_in[g]       = grp_sel[g].valid;
            glb_level_in[g*4 +: 4] = grp_sel[g].level;
        end
    end

    intc_prio_grp #(
        .NumIn (NumGrp)
    ) u_glb (
        .valid_i (glb_valid_in),
        .level_i (glb_level_in),
        .valid_o (glb_v),
        .level_o (glb_l),
        .index_o (glb_g)
    );

    intc_win_t gw_d, gw_q;

    always_comb begin
        gw_d       = '0;
        gw_d.valid = glb_v;
        gw_d.level = glb_l;
        if (glb_v) begin
            for (int unsigned g = 0; g < NumGrp; g++) begin
                if (glb_g == INTC_IDX_W'(g)) begin
                    gw_d.index = grp_sel[g].index;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gw_q <= '0;
        end else begin
            gw_q <= gw_d;
        end
    end

    // -------------------------------------------------------------------------
    // CPU handshake FSM
    // -------------------------------------------------------------------------
    intc_arb_st_e          st_q, st_d;
    logic [1:0]            flush_cnt_q, flush_cnt_d;
    logic                  ack_q, ack_d;
    logic [INTC_IDX_W-1:0] ack_idx_q, ack_idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= IDLE;
            flush_cnt_q <= '0;
            ack_q       <= 1'b0;
            ack_idx_q   <= '0;
        end else begin
            st_q        <= st_d;
            flush_cnt_q <= flush_cnt_d;
            ack_q       <= ack_d;
            ack_idx_q   <= ack_idx_d;
        end
    end

    always_comb begin
        st_d        = st_q;
        flush_cnt_d = flush_cnt_q;
        ack_d       = 1'b0;
        ack_idx_d   = ack_idx_q;
        case (st_q)
            IDLE: begin
                if (gw_q.valid) begin
                    st_d = REQ;
                end
            end
            REQ: begin
                // Nothing valid on the outputs: an ack has no source to accept.
                if (!gw_q.valid) begin
                    st_d = IDLE;
                end else if (cpu_ack_i) begin
                    // Accept the index the CPU saw this cycle, not a newer winner.
                    st_d        = FLUSH;
                    flush_cnt_d = 2'(FLUSH_CYC - 1);
                    ack_d       = 1'b1;
                    ack_idx_d   = gw_q.index;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == '0) begin
                    st_d = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 2'd1;
                end
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

    always_comb begin
        intc_req_o   = 1'b0;
        intc_level_o = '0;
        intc_vec_o   = '0;
        if (st_q == REQ) begin
            intc_req_o   = 1'b1;
            intc_level_o = gw_q.level;
            intc_vec_o   = VEC_BASE + gw_q.index;
        end
        cp_intack_o = '0;
        for (int unsigned i = 0; i < INT_DW; i++) begin
            cp_intack_o[i] = ack_q && (ack_idx_q == INTC_IDX_W'(i));
        end
    end

endmodule

// File: tb/tb_intc_prio_arb.sv
module tb_intc_prio_arb;

    localparam int unsigned INT_DW   = 64;
    localparam logic [7:0]  VEC_BASE = 8'd64;

`ifdef INTC_PRIO_PIPE_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int LAT       = DEPTH + 1;
    localparam int FLUSH_CYC = DEPTH + 1;

    localparam int MS_IDLE  = 0;
    localparam int MS_REQ   = 1;
    localparam int MS_FLUSH = 2;

    logic                clk;
    logic                rst_n;
    logic [INT_DW-1:0]   in_intreq;
    logic [INT_DW*4-1:0] ipr;
    logic [3:0]          mask;
    logic                ack;
    logic                intc_req;
    logic [3:0]          intc_level;
    logic [7:0]          intc_vec;
    logic [INT_DW-1:0]   cp_intack;

    int n_tests;
    int n_fail;

    intc_prio_arb #(
        .INT_DW   (INT_DW),
        .VEC_BASE (VEC_BASE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_intreq_i  (in_intreq),
        .rg_ipr_i     (ipr),
        .rg_imask_i   (mask),
        .intc_req_o   (intc_req),
        .intc_level_o (intc_level),
        .intc_vec_o   (intc_vec),
        .cpu_ack_i    (ack),
        .cp_intack_o  (cp_intack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: winner from the selection rule, delayed by the
    // pipeline depth, feeding an idle / request / flush handshake.
    // Winner record packs {valid, level[3:0], index[7:0]}.
    // ------------------------------------------------------------------
    function automatic logic [12:0] ref_winner(input logic [INT_DW-1:0] r,
                                               input logic [INT_DW*4-1:0] p,
                                               input logic [3:0] mk);
        int best;
        int bl;
        int pl;
        best = -1;
        bl   = 0;
        for (int i = 0; i < INT_DW; i++) begin
            pl = int'(p[i*4 +: 4]);
            if (r[i] && pl != 0 && pl > int'(mk) && pl > bl) begin
                best = i;
                bl   = pl;
            end
        end
        if (best < 0) return 13'd0;
        return {1'b1, 4'(bl), 8'(best)};
    endfunction

    logic [12:0] m_s1;
    logic [12:0] m_gw;
    int          m_st;
    int          m_rem;
    logic        m_ack;
    logic [7:0]  m_ack_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1      <= '0;
            m_gw      <= '0;
            m_st      <= MS_IDLE;
            m_rem     <= 0;
            m_ack     <= 1'b0;
            m_ack_idx <= '0;
        end else begin
            m_s1  <= ref_winner(in_intreq, ipr, mask);
            m_gw  <= (DEPTH == 2) ? m_s1 : ref_winner(in_intreq, ipr, mask);
            m_ack <= 1'b0;
            case (m_st)
                MS_IDLE: if (m_gw[12]) m_st <= MS_REQ;
                MS_REQ: begin
                    if (!m_gw[12]) begin
                        m_st <= MS_IDLE;
                    end else if (ack) begin
                        m_st      <= MS_FLUSH;
                        m_rem     <= FLUSH_CYC;
                        m_ack     <= 1'b1;
                        m_ack_idx <= m_gw[7:0];
                    end
                end
                default: begin
                    if (m_rem == 1) m_st <= MS_IDLE;
                    m_rem <= m_rem - 1;
                end
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_prio(input int idx, input int p);
        ipr[idx*4 +: 4] = 4'(p);
    endtask

    task automatic clear_all;
        in_intreq = '0;
        ipr       = '0;
        mask      = '0;
        ack       = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset;
        clear_all;
        rst_n = 1'b0;
        #2;
        n_tests++;
        if (intc_req !== 1'b0 || intc_level !== 4'd0 || intc_vec !== 8'd0 ||
            cp_intack !== '0) begin
            n_fail++;
            $display("FAIL reset_t0: got req=%b lvl=%0d vec=%0d ack=%h required all zero",
                     intc_req, intc_level, intc_vec, cp_intack);
        end
        set_prio(3, 5);
        in_intreq[3] = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if (intc_req !== 1'b0 || cp_intack !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got req=%b ack=%h required 0/0", intc_req, cp_intack);
        end
        clear_all;
        rst_n = 1'b1;
    endtask

    task automatic test_single_ack;
        clear_all;
        do_reset;
        set_prio(5, 3);
        in_intreq[5] = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        n_tests++;
        if (intc_req !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: got req=%b required 0", intc_req);
        end
        @(negedge clk);
        n_tests++;
        if (intc_req !== 1'b1 || intc_level !== 4'd3 || intc_vec !== 8'd69) begin
            n_fail++;
            $display("FAIL single_req: got req=%b lvl=%0d vec=%0d required 1/3/69",
                     intc_req, intc_level, intc_vec);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        n_tests++;
        if (cp_intack !== 64'h20 || intc_req !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse: got ack=%h req=%b required 0000000000000020/0",
                     cp_intack, intc_req);
        end
        in_intreq[5] = 1'b0;
        @(negedge clk);
        n_tests++;
        if (cp_intack !== '0) begin
            n_fail++;
            $display("FAIL single_pulse_len: got ack=%h required 0", cp_intack);
        end
        repeat (FLUSH_CYC + 2) @(negedge clk);
        n_tests++;
        if (intc_req !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: got req=%b required 0", intc_req);
        end
    endtask

    task automatic test_back_to_back;
        clear_all;
        do_reset;
        set_prio(5, 3);
        set_prio(6, 2);
        in_intreq[5] = 1'b1;
        in_intreq[6] = 1'b1;
        repeat (LAT) @(negedge clk);
        n_tests++;
        if (intc_vec !== 8'd69) begin
            n_fail++;
            $display("FAIL b2b_first: got vec=%0d required 69", intc_vec);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        n_tests++;
        if (cp_intack !== 64'h20) begin
            n_fail++;
            $display("FAIL b2b_pulse: got ack=%h required 0000000000000020", cp_intack);
        end
        @(negedge clk);
        in_intreq[5] = 1'b0;
        n_tests++;
        if (intc_req !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_flush1: got req=%b required 0", intc_req);
        end
        for (int k = 2; k <= FLUSH_CYC; k++) begin
            @(negedge clk);
            n_tests++;
            if (intc_req !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_flush%0d: got req=%b required 0", k, intc_req);
            end
        end
        @(negedge clk);
        n_tests++;
        if (intc_req !== 1'b1 || intc_level !== 4'd2 || intc_vec !== 8'd70) begin
            n_fail++;
            $display("FAIL b2b_next: got req=%b lvl=%0d vec=%0d required 1/2/70",
                     intc_req, intc_level, intc_vec);
        end
    endtask

    task automatic test_tie_preempt;
        clear_all;
        do_reset;
        set_prio(2, 7);
        set_prio(40, 7);
        in_intreq[2]  = 1'b1;
        in_intreq[40] = 1'b1;
        repeat (LAT) @(negedge clk);
        n_tests++;
        if (intc_req !== 1'b1 || intc_level !== 4'd7 || intc_vec !== 8'd66) begin
            n_fail++;
            $display("FAIL tie_low_index: got req=%b lvl=%0d vec=%0d required 1/7/66",
                     intc_req, intc_level, intc_vec);
        end
        set_prio(40, 9);
        repeat (DEPTH) @(negedge clk);
        n_tests++;
        if (intc_req !== 1'b1 || intc_level !== 4'd9 || intc_vec !== 8'd104) begin
            n_fail++;
            $display("FAIL preempt: got req=%b lvl=%0d vec=%0d required 1/9/104",
                     intc_req, intc_level, intc_vec);
        end
    endtask

    task automatic test_mask;
        clear_all;
        do_reset;
        set_prio(10, 4);
        mask          = 4'd4;
        in_intreq[10] = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        n_tests++;
        if (intc_req !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_block: got req=%b required 0", intc_req);
        end
        mask = 4'd3;
        repeat (LAT) @(negedge clk);
        n_tests++;
        if (intc_req !== 1'b1 || intc_level !== 4'd4 || intc_vec !== 8'd74) begin
            n_fail++;
            $display("FAIL mask_open: got req=%b lvl=%0d vec=%0d required 1/4/74",
                     intc_req, intc_level, intc_vec);
        end
    endtask

    task automatic test_ack_collision;
        clear_all;
        do_reset;
        set_prio(10, 4);
        in_intreq[10] = 1'b1;
        repeat (LAT) @(negedge clk);
        n_tests++;
        if (intc_vec !== 8'd74) begin
            n_fail++;
            $display("FAIL coll_first: got vec=%0d required 74", intc_vec);
        end
        ack = 1'b1;
        set_prio(20, 12);
        in_intreq[20] = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        n_tests++;
        if (cp_intack !== 64'h400) begin
            n_fail++;
            $display("FAIL coll_pulse: got ack=%h required 0000000000000400", cp_intack);
        end
        @(negedge clk);
        in_intreq[10] = 1'b0;
        n_tests++;
        if (cp_intack !== '0 || intc_req !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_flush1: got ack=%h req=%b required 0/0", cp_intack, intc_req);
        end
        for (int k = 2; k <= FLUSH_CYC; k++) begin
            @(negedge clk);
            n_tests++;
            if (intc_req !== 1'b0) begin
                n_fail++;
                $display("FAIL coll_flush%0d: got req=%b required 0", k, intc_req);
            end
        end
        @(negedge clk);
        n_tests++;
        if (intc_req !== 1'b1 || intc_level !== 4'd12 || intc_vec !== 8'd84) begin
            n_fail++;
            $display("FAIL coll_next: got req=%b lvl=%0d vec=%0d required 1/12/84",
                     intc_req, intc_level, intc_vec);
        end
    endtask

    task automatic test_ack_idle;
        clear_all;
        do_reset;
        set_prio(7, 2);
        mask         = 4'd5;
        in_intreq[7] = 1'b1;
        ack          = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests++;
            if (cp_intack !== '0 || intc_req !== 1'b0) begin
                n_fail++;
                $display("FAIL ack_idle%0d: got ack=%h req=%b required 0/0",
                         k, cp_intack, intc_req);
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_reset_mid;
        clear_all;
        do_reset;
        set_prio(5, 3);
        in_intreq[5] = 1'b1;
        repeat (LAT) @(negedge clk);
        n_tests++;
        if (intc_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got req=%b required 1", intc_req);
        end
        ack = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (intc_req !== 1'b0 || intc_level !== 4'd0 || intc_vec !== 8'd0 ||
            cp_intack !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: got req=%b lvl=%0d vec=%0d ack=%h required all zero",
                     intc_req, intc_level, intc_vec, cp_intack);
        end
        @(negedge clk);
        ack = 1'b0;
        n_tests++;
        if (cp_intack !== '0) begin
            n_fail++;
            $display("FAIL rstmid_nopulse: got ack=%h required 0", cp_intack);
        end
        rst_n = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        n_tests++;
        if (intc_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_early: got req=%b required 0", intc_req);
        end
        @(negedge clk);
        n_tests++;
        if (intc_req !== 1'b1 || intc_vec !== 8'd69) begin
            n_fail++;
            $display("FAIL rstmid_rereq: got req=%b vec=%0d required 1/69", intc_req, intc_vec);
        end
    endtask

    task automatic test_random;
        logic [INT_DW-1:0] exp_ack;
        logic [INT_DW-1:0] clr_next;
        logic              exp_req;
        logic [7:0]        exp_vec;
        clear_all;
        do_reset;
        for (int i = 0; i < INT_DW; i++) set_prio(i, int'($urandom_range(0, 15)));
        clr_next = '0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            exp_req = (m_st == MS_REQ);
            n_tests++;
            if (intc_req !== exp_req) begin
                n_fail++;
                $display("FAIL rand_req c=%0d: got %b required %b", c, intc_req, exp_req);
            end
            if (exp_req && m_gw[12]) begin
                exp_vec = VEC_BASE + m_gw[7:0];
                n_tests++;
                if (intc_level !== m_gw[11:8] || intc_vec !== exp_vec) begin
                    n_fail++;
                    $display("FAIL rand_lvlvec c=%0d: got %0d/%0d required %0d/%0d",
                             c, intc_level, intc_vec, m_gw[11:8], exp_vec);
                end
            end
            exp_ack = '0;
            for (int i = 0; i < INT_DW; i++) exp_ack[i] = m_ack && (m_ack_idx == 8'(i));
            n_tests++;
            if (cp_intack !== exp_ack) begin
                n_fail++;
                $display("FAIL rand_intack c=%0d: got %h required %h", c, cp_intack, exp_ack);
            end
            // Capture stage clears an accepted bit on the edge after its pulse.
            in_intreq = in_intreq & ~clr_next;
            clr_next  = exp_ack;
            if ($urandom_range(0, 3) == 0)
                in_intreq = in_intreq | (64'd1 << $urandom_range(0, INT_DW - 1));
            if ($urandom_range(0, 15) == 0)
                in_intreq = in_intreq & ~(64'd1 << $urandom_range(0, INT_DW - 1));
            if ($urandom_range(0, 7) == 0)
                set_prio(int'($urandom_range(0, INT_DW - 1)), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 31) == 0)
                mask = 4'($urandom_range(0, 6));
            ack = ($urandom_range(0, 3) == 0);
        end
        ack = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        clear_all;
        test_reset;
        test_single_ack;
        test_back_to_back;
        test_tie_preempt;
        test_mask;
        test_ack_collision;
        test_ack_idle;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
